rgb_pwm_driver: RTL and testbench

Downstream consumer of the RGB colour converter. Takes the 24-bit RGB code and drives three PWM outputs for a common RGB LED. Duty cycles are double-buffered, so a colour change only takes effect at a PWM period boundary and the LED output never glitches.

---
 rtl/rgb_pkg.sv | 25 ++
 rtl/pwm_channel.sv | 55 +++++
 rtl/rgb_pwm_driver.sv | 131 +++++++++++++
 tb/tb_rgb_pwm_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg
// Shared definitions for the 24-bit RGB colour format. The colour converter and
// the PWM driver both import this package, so the field layout is defined once.
//   CH_W           bits per colour channel
//   R_LSB/G_LSB/B_LSB  bit offsets of each channel inside an rgb_t word
//   rgb_t          packed 24-bit colour code, R in the top byte
//   duty_t         one channel's duty value
//   get_channel()  extracts one channel from a colour code given its LSB offset
package rgb_pkg;

  localparam int CH_W  = 8;
  localparam int RGB_W = 3 * CH_W;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [CH_W-1:0]  duty_t;

  function automatic duty_t get_channel(input rgb_t code, input int lsb);
    return code[lsb +: CH_W];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One colour channel of the RGB PWM driver: holds the duty value currently in
// use and produces the registered PWM compare output.
//   clk, rst     clock and asynchronous active-high reset
//   enable       PWM run enable; output is forced low when 0
//   cnt          shared PWM counter from the top level
//   update       duty may change this cycle (counter wrap, or driver idle)
//   bypass       a fresh colour is on the input bus this cycle and wins
//   pend_valid   the buffered duty is waiting to be applied
//   load_duty    this channel's field of the incoming colour
//   pend_duty    this channel's field of the buffered colour
//   pwm          PWM drive, high while cnt < active duty
module pwm_channel
  import rgb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [CH_W-1:0] cnt,
  input  logic            update,
  input  logic            bypass,
  input  logic            pend_valid,
  input  logic [CH_W-1:0] load_duty,
  input  logic [CH_W-1:0] pend_duty,
  output logic            pwm
);

  duty_t active;

  // The active duty only changes when the top says it is safe to do so: at a
  // period boundary, or any cycle while the driver is idle. A colour arriving
  // in that same cycle beats the older buffered one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
    end else if (update) begin
      if (bypass) begin
        active <= load_duty;
      end else if (pend_valid) begin
        active <= pend_duty;
      end
    end
  end

  // Registered compare so the LED pin is glitch-free. High time per period
  // is active * PRESCALE clocks; duty 255 leaves only the cnt==255 slot low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= enable && (cnt < active);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver
// Drives a common RGB LED from a 24-bit colour code with three PWM outputs.
// New colours are buffered and applied only at a PWM period boundary, so a
// colour change never cuts a period short.
//   clk, rst        clock and asynchronous active-high reset
//   enable          PWM run enable; idle holds the counter at 0, outputs low
//   rgb_valid       single-cycle strobe, rgb carries a new colour
//   rgb             colour code, [23:16]=R [15:8]=G [7:0]=B
//   pwm_r/g/b       PWM drives
//   period_start    one-cycle pulse in the first cycle after a counter wrap
//   update_pending  a buffered colour is waiting for the next boundary
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rgb_valid,
  input  logic [23:0] rgb,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        period_start,
  output logic        update_pending
);

  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  duty_t         cnt;
  rgb_t          pending;
  logic          pend_flag;
  logic          tick;
  logic          wrap;
  logic          update;

  assign tick   = enable && (presc == PRESC_MAX);
  assign wrap   = tick && (cnt == '1);
  // While idle the duty registers track the input every cycle, so a colour
  // loaded before enable rises is already live for the first period.
  assign update = wrap || !enable;

  assign update_pending = pend_flag;

  // Prescaler and PWM counter. Both are parked at 0 while idle, so enabling
  // always starts a clean period at cnt=0 without a period_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + CH_W'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Pending colour buffer; the last load before a boundary wins. The flag is
  // cleared whenever the channels take an update, including a bypass load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (rgb_valid) begin
        pending <= rgb;
      end
      if (update) begin
        pend_flag <= 1'b0;
      end else if (rgb_valid) begin
        pend_flag <= 1'b1;
      end
    end
  end

  // period_start lands in the cycle where cnt and presc have just returned to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  pwm_channel u_red (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cnt        (cnt),
    .update     (update),
    .bypass     (rgb_valid),
    .pend_valid (pend_flag),
    .load_duty  (get_channel(rgb, R_LSB)),
    .pend_duty  (get_channel(pending, R_LSB)),
    .pwm        (pwm_r)
  );

  pwm_channel u_green (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cnt        (cnt),
    .update     (update),
    .bypass     (rgb_valid),
    .pend_valid (pend_flag),
    .load_duty  (get_channel(rgb, G_LSB)),
    .pend_duty  (get_channel(pending, G_LSB)),
    .pwm        (pwm_g)
  );

  pwm_channel u_blue (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cnt        (cnt),
    .update     (update),
    .bypass     (rgb_valid),
    .pend_valid (pend_flag),
    .load_duty  (get_channel(rgb, B_LSB)),
    .pend_duty  (get_channel(pending, B_LSB)),
    .pwm        (pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver
// Directed bench for rgb_pwm_driver with PRESCALE=4 (1024-clock periods).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        rgb_valid;
  logic [23:0] rgb;
  logic        pwm_r, pwm_g, pwm_b, period_start, update_pending;

  int checks = 0;
  int passed = 0;

  rgb_pwm_driver #(.PRESCALE(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .rgb_valid      (rgb_valid),
    .rgb            (rgb),
    .pwm_r          (pwm_r),
    .pwm_g          (pwm_g),
    .pwm_b          (pwm_b),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  always #5 clk = ~clk;

  // Runs one full period starting from a cycle where cnt=0,presc=0. Sample i
  // reflects the counter state of cycle i-1, so samples 1..1024 cover exactly
  // one period and period_start appears only at sample 1024. Loads are driven
  // for the cycle following sample l1 / l2.
  task automatic run_window(input int l1, input logic [23:0] v1,
                            input int l2, input logic [23:0] v2,
                            input int probe,
                            output int hr, output int hg, output int hb,
                            output int ps_n, output logic ps_last,
                            output logic upd_probe, output logic upd_pre,
                            output logic upd_last, output logic upd_any);
    hr = 0; hg = 0; hb = 0; ps_n = 0; ps_last = 1'b0;
    upd_probe = 1'b0; upd_pre = 1'b0; upd_last = 1'b0; upd_any = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      hr += int'(pwm_r);
      hg += int'(pwm_g);
      hb += int'(pwm_b);
      ps_n += int'(period_start);
      if (update_pending) upd_any = 1'b1;
      if (i == probe) upd_probe = update_pending;
      if (i == 1023) upd_pre = update_pending;
      if (i == 1024) begin
        ps_last  = period_start;
        upd_last = update_pending;
      end
      if (i == l1) begin
        rgb_valid = 1'b1; rgb = v1;
      end else if (i == l2) begin
        rgb_valid = 1'b1; rgb = v2;
      end else begin
        rgb_valid = 1'b0;
      end
    end
  endtask

  int   hr, hg, hb, psn;
  logic psl, updp, updpre, updl, upda;

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; rgb_valid = 1'b1; rgb = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    checks++; if ({pwm_r, pwm_g, pwm_b} !== 3'b000) $display("[TB] FAIL reset_pwm: got %b expected 000", {pwm_r, pwm_g, pwm_b}); else passed++;
    checks++; if (period_start !== 1'b0) $display("[TB] FAIL reset_period_start: got %b expected 0", period_start); else passed++;
    checks++; if (update_pending !== 1'b0) $display("[TB] FAIL reset_update_pending: got %b expected 0", update_pending); else passed++;
    rst = 1'b0; rgb_valid = 1'b0; rgb = '0;
    hr = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hr += int'(pwm_r) + int'(pwm_g) + int'(pwm_b) + int'(update_pending);
    end
    checks++; if (hr !== 0) $display("[TB] FAIL reset_no_colour_output: got %0d high samples expected 0", hr); else passed++;
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_idle_load();
    rgb_valid = 1'b1; rgb = 24'hFF8000;
    @(negedge clk);
    rgb_valid = 1'b0;
    checks++; if (update_pending !== 1'b0) $display("[TB] FAIL idle_load_pending: got %b expected 0", update_pending); else passed++;
    enable = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
      checks++; if (hr !== 1020) $display("[TB] FAIL idle_run_r w%0d: got %0d expected 1020", w, hr); else passed++;
      checks++; if (hg !== 512) $display("[TB] FAIL idle_run_g w%0d: got %0d expected 512", w, hg); else passed++;
      checks++; if (hb !== 0) $display("[TB] FAIL idle_run_b w%0d: got %0d expected 0", w, hb); else passed++;
      checks++; if (psn !== 1 || psl !== 1'b1) $display("[TB] FAIL idle_run_period_start w%0d: got count %0d last %b expected 1 and 1", w, psn, psl); else passed++;
    end
  endtask

  task automatic test_mid_update();
    // Establish 0x404040 as the active colour for the next period.
    run_window(10, 24'h404040, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 1020 || hg !== 512 || hb !== 0) $display("[TB] FAIL mid_setup_old_colour: got %0d/%0d/%0d expected 1020/512/0", hr, hg, hb); else passed++;
    // Load 0x808080 while cnt=100 (cycle 400).
    run_window(400, 24'h808080, -1, '0, 401, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 256 || hg !== 256 || hb !== 256) $display("[TB] FAIL mid_current_period: got %0d/%0d/%0d expected 256/256/256", hr, hg, hb); else passed++;
    checks++; if (updp !== 1'b1) $display("[TB] FAIL mid_pending_after_load: got %b expected 1", updp); else passed++;
    checks++; if (updpre !== 1'b1) $display("[TB] FAIL mid_pending_before_wrap: got %b expected 1", updpre); else passed++;
    checks++; if (updl !== 1'b0) $display("[TB] FAIL mid_pending_after_wrap: got %b expected 0", updl); else passed++;
    run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 512 || hg !== 512 || hb !== 512) $display("[TB] FAIL mid_next_period: got %0d/%0d/%0d expected 512/512/512", hr, hg, hb); else passed++;
  endtask

  task automatic test_back_to_back();
    run_window(100, 24'h101010, 600, 24'h202020, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 512 || hg !== 512 || hb !== 512) $display("[TB] FAIL b2b_current_period: got %0d/%0d/%0d expected 512/512/512", hr, hg, hb); else passed++;
    run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 128 || hg !== 128 || hb !== 128) $display("[TB] FAIL b2b_last_wins: got %0d/%0d/%0d expected 128/128/128", hr, hg, hb); else passed++;
  endtask

  task automatic test_wrap_load();
    // Cycle 1023 is the wrap cycle (cnt=255, presc=3).
    run_window(1023, 24'h00FF00, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 128 || hg !== 128 || hb !== 128) $display("[TB] FAIL wrap_current_period: got %0d/%0d/%0d expected 128/128/128", hr, hg, hb); else passed++;
    checks++; if (updl !== 1'b0 || upda !== 1'b0) $display("[TB] FAIL wrap_no_pending: got last %b any %b expected 0 and 0", updl, upda); else passed++;
    run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 0 || hg !== 1020 || hb !== 0) $display("[TB] FAIL wrap_bypass_colour: got %0d/%0d/%0d expected 0/1020/0", hr, hg, hb); else passed++;
    checks++; if (upda !== 1'b0) $display("[TB] FAIL wrap_pending_stays_low: got %b expected 0", upda); else passed++;
  endtask

  task automatic test_enable_drop();
    // Run to cycle 200 (cnt=50), then drop enable.
    for (int i = 1; i <= 200; i++) @(negedge clk);
    checks++; if (pwm_g !== 1'b1) $display("[TB] FAIL drop_before_g: got %b expected 1", pwm_g); else passed++;
    enable = 1'b0;
    @(negedge clk);
    checks++; if ({pwm_r, pwm_g, pwm_b, period_start} !== 4'b0000) $display("[TB] FAIL drop_outputs_low: got %b expected 0000", {pwm_r, pwm_g, pwm_b, period_start}); else passed++;
    hr = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hr += int'(pwm_r) + int'(pwm_g) + int'(pwm_b) + int'(period_start);
    end
    checks++; if (hr !== 0) $display("[TB] FAIL drop_idle_low: got %0d high samples expected 0", hr); else passed++;
    enable = 1'b1;
    run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 0 || hg !== 1020 || hb !== 0) $display("[TB] FAIL drop_reenable_period: got %0d/%0d/%0d expected 0/1020/0", hr, hg, hb); else passed++;
    checks++; if (psn !== 1 || psl !== 1'b1) $display("[TB] FAIL drop_reenable_period_start: got count %0d last %b expected 1 and 1", psn, psl); else passed++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 100) begin
        rgb_valid = 1'b1; rgb = 24'h123456;
      end else begin
        rgb_valid = 1'b0;
      end
    end
    checks++; if (pwm_g !== 1'b1 || update_pending !== 1'b1) $display("[TB] FAIL midreset_before: got g %b pending %b expected 1 and 1", pwm_g, update_pending); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if ({pwm_r, pwm_g, pwm_b, period_start, update_pending} !== 5'b00000) $display("[TB] FAIL midreset_immediate: got %b expected 00000", {pwm_r, pwm_g, pwm_b, period_start, update_pending}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_window(-1, '0, -1, '0, -1, hr, hg, hb, psn, psl, updp, updpre, updl, upda);
    checks++; if (hr !== 0 || hg !== 0 || hb !== 0 || upda !== 1'b0) $display("[TB] FAIL midreset_cleared: got %0d/%0d/%0d pending %b expected 0/0/0 and 0", hr, hg, hb, upda); else passed++;
    checks++; if (psn !== 1 || psl !== 1'b1) $display("[TB] FAIL midreset_period_start: got count %0d last %b expected 1 and 1", psn, psl); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_mid_update();
    test_back_to_back();
    test_wrap_load();
    test_enable_drop();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
